// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle: decode fields, hazard sources, registered EX fields.
// slave is the pipeline register's view; master is the driver/observer view.
interface id_ex_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
);
    // stage control
    logic              freeze;
    logic              flush;
    logic              forward_en;

    // decode-stage outputs
    logic              valid_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] val_rn_in;
    logic [DATA_W-1:0] val_rm_in;
    logic [23:0]       imm24_in;
    logic [11:0]       shift_operand_in;
    logic [3:0]        exe_cmd_in;
    logic [REG_W-1:0]  dest_in;
    logic [REG_W-1:0]  src1_in;
    logic [REG_W-1:0]  src2_in;
    logic              two_src_in;
    logic              wb_en_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              s_in;
    logic              b_in;
    logic              imm_in;
    logic [3:0]        status_in;

    // destinations still in flight downstream
    logic [REG_W-1:0]  exe_dest;
    logic [REG_W-1:0]  mem_dest;
    logic              exe_wb_en;
    logic              mem_wb_en;
    logic              exe_mem_r_en;

    // stage results
    logic              hazard;
    logic              valid_out;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] val_rn_out;
    logic [DATA_W-1:0] val_rm_out;
    logic [23:0]       imm24_out;
    logic [11:0]       shift_operand_out;
    logic [3:0]        exe_cmd_out;
    logic [REG_W-1:0]  dest_out;
    logic [REG_W-1:0]  src1_out;
    logic [REG_W-1:0]  src2_out;
    logic              wb_en_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              s_out;
    logic              b_out;
    logic              imm_out;
    logic [3:0]        status_out;
    logic [CNT_W-1:0]  bubble_count;

    modport slave (
        input  freeze, flush, forward_en,
        input  valid_in, pc_in, val_rn_in, val_rm_in, imm24_in, shift_operand_in,
        input  exe_cmd_in, dest_in, src1_in, src2_in, two_src_in,
        input  wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in, status_in,
        input  exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_r_en,
        output hazard,
        output valid_out, pc_out, val_rn_out, val_rm_out, imm24_out, shift_operand_out,
        output exe_cmd_out, dest_out, src1_out, src2_out,
        output wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out, imm_out, status_out,
        output bubble_count
    );

    modport master (
        output freeze, flush, forward_en,
        output valid_in, pc_in, val_rn_in, val_rm_in, imm24_in, shift_operand_in,
        output exe_cmd_in, dest_in, src1_in, src2_in, two_src_in,
        output wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in, status_in,
        output exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_r_en,
        input  hazard,
        input  valid_out, pc_out, val_rn_out, val_rm_out, imm24_out, shift_operand_out,
        input  exe_cmd_out, dest_out, src1_out, src2_out,
        input  wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out, imm_out, status_out,
        input  bubble_count
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with read-after-write hazard detection,
// bubble insertion, freeze/flush handling and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_ex_stage_reg_if.slave   bus
);

    logic              m_exe1, m_exe2, m_mem1, m_mem2;
    logic              hit1, hit2;
    logic              hazard_c;
    logic              take_bubble, take_input, count_inc;

    logic              valid_q,         valid_d;
    logic [DATA_W-1:0] pc_q,            pc_d;
    logic [DATA_W-1:0] val_rn_q,        val_rn_d;
    logic [DATA_W-1:0] val_rm_q,        val_rm_d;
    logic [23:0]       imm24_q,         imm24_d;
    logic [11:0]       shift_operand_q, shift_operand_d;
    logic [3:0]        exe_cmd_q,       exe_cmd_d;
    logic [REG_W-1:0]  dest_q,          dest_d;
    logic [REG_W-1:0]  src1_q,          src1_d;
    logic [REG_W-1:0]  src2_q,          src2_d;
    logic              wb_en_q,         wb_en_d;
    logic              mem_r_en_q,      mem_r_en_d;
    logic              mem_w_en_q,      mem_w_en_d;
    logic              s_q,             s_d;
    logic              b_q,             b_d;
    logic              imm_q,           imm_d;
    logic [3:0]        status_q,        status_d;
    logic [CNT_W-1:0]  cnt_q,           cnt_d;

    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        m_exe1 = bus.exe_wb_en & (bus.src1_in == bus.exe_dest);
        m_exe2 = bus.exe_wb_en & (bus.src2_in == bus.exe_dest);
        m_mem1 = bus.mem_wb_en & (bus.src1_in == bus.mem_dest);
        m_mem2 = bus.mem_wb_en & (bus.src2_in == bus.mem_dest);
        if (bus.forward_en) begin
            hit1 = bus.exe_mem_r_en & m_exe1;
            hit2 = bus.exe_mem_r_en & m_exe2;
        end else begin
            hit1 = m_exe1 | m_mem1;
            hit2 = m_exe2 | m_mem2;
        end
        hazard_c = bus.valid_in & (hit1 | (bus.two_src_in & hit2));
    end

    assign bus.hazard = hazard_c;

    // Priority: flush, then freeze (hold), then hazard bubble, then load.
    always_comb begin
        take_bubble = bus.flush | (~bus.freeze & hazard_c);
        take_input  = ~bus.flush & ~bus.freeze & ~hazard_c;
        count_inc   = ~bus.flush & ~bus.freeze & hazard_c & (cnt_q != '1);
    end

    always_comb begin
        valid_d         = valid_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm24_d         = imm24_q;
        shift_operand_d = shift_operand_q;
        exe_cmd_d       = exe_cmd_q;
        dest_d          = dest_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        wb_en_d         = wb_en_q;
        mem_r_en_d      = mem_r_en_q;
        mem_w_en_d      = mem_w_en_q;
        s_d             = s_q;
        b_d             = b_q;
        imm_d           = imm_q;
        status_d        = status_q;
        if (take_bubble) begin
            valid_d         = 1'b0;
            pc_d            = '0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            imm24_d         = '0;
            shift_operand_d = '0;
            exe_cmd_d       = '0;
            dest_d          = '0;
            src1_d          = '0;
            src2_d          = '0;
            wb_en_d         = 1'b0;
            mem_r_en_d      = 1'b0;
            mem_w_en_d      = 1'b0;
            s_d             = 1'b0;
            b_d             = 1'b0;
            imm_d           = 1'b0;
            status_d        = '0;
        end else if (take_input) begin
            valid_d         = bus.valid_in;
            pc_d            = bus.pc_in;
            val_rn_d        = bus.val_rn_in;
            val_rm_d        = bus.val_rm_in;
            imm24_d         = bus.imm24_in;
            shift_operand_d = bus.shift_operand_in;
            exe_cmd_d       = bus.exe_cmd_in;
            dest_d          = bus.dest_in;
            src1_d          = bus.src1_in;
            src2_d          = bus.src2_in;
            wb_en_d         = bus.wb_en_in;
            mem_r_en_d      = bus.mem_r_en_in;
            mem_w_en_d      = bus.mem_w_en_in;
            s_d             = bus.s_in;
            b_d             = bus.b_in;
            imm_d           = bus.imm_in;
            status_d        = bus.status_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (count_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q         <= 1'b0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm24_q         <= '0;
            shift_operand_q <= '0;
            exe_cmd_q       <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            wb_en_q         <= 1'b0;
            mem_r_en_q      <= 1'b0;
            mem_w_en_q      <= 1'b0;
            s_q             <= 1'b0;
            b_q             <= 1'b0;
            imm_q           <= 1'b0;
            status_q        <= '0;
            cnt_q           <= '0;
        end else begin
            valid_q         <= valid_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm24_q         <= imm24_d;
            shift_operand_q <= shift_operand_d;
            exe_cmd_q       <= exe_cmd_d;
            dest_q          <= dest_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            wb_en_q         <= wb_en_d;
            mem_r_en_q      <= mem_r_en_d;
            mem_w_en_q      <= mem_w_en_d;
            s_q             <= s_d;
            b_q             <= b_d;
            imm_q           <= imm_d;
            status_q        <= status_d;
            cnt_q           <= cnt_d;
        end
    end

    assign bus.valid_out         = valid_q;
    assign bus.pc_out            = pc_q;
    assign bus.val_rn_out        = val_rn_q;
    assign bus.val_rm_out        = val_rm_q;
    assign bus.imm24_out         = imm24_q;
    assign bus.shift_operand_out = shift_operand_q;
    assign bus.exe_cmd_out       = exe_cmd_q;
    assign bus.dest_out          = dest_q;
    assign bus.src1_out          = src1_q;
    assign bus.src2_out          = src2_q;
    assign bus.wb_en_out         = wb_en_q;
    assign bus.mem_r_en_out      = mem_r_en_q;
    assign bus.mem_w_en_out      = mem_w_en_q;
    assign bus.s_out             = s_q;
    assign bus.b_out             = b_q;
    assign bus.imm_out           = imm_q;
    assign bus.status_out        = status_q;
    assign bus.bubble_count      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed and randomized checks of id_ex_stage_reg against a record-level
// reference: one instruction record per stage, hazards from pending-write sets.
module tb_id_ex_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_MAX = 65535;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rn, rm;
        logic [23:0] imm24;
        logic [11:0] sh;
        logic [3:0]  cmd, dest, s1, s2;
        logic        wb, mr, mw, s, b, imm;
        logic [3:0]  st;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    rec_t exp_r;
    int unsigned exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic rec_t zero_rec();
        rec_t r;
        r.valid = 0; r.pc = 0; r.rn = 0; r.rm = 0; r.imm24 = 0; r.sh = 0;
        r.cmd = 0; r.dest = 0; r.s1 = 0; r.s2 = 0; r.wb = 0; r.mr = 0;
        r.mw = 0; r.s = 0; r.b = 0; r.imm = 0; r.st = 0;
        return r;
    endfunction

    function automatic rec_t capture();
        rec_t r;
        r.valid = bus.valid_in; r.pc = bus.pc_in; r.rn = bus.val_rn_in; r.rm = bus.val_rm_in;
        r.imm24 = bus.imm24_in; r.sh = bus.shift_operand_in; r.cmd = bus.exe_cmd_in;
        r.dest = bus.dest_in; r.s1 = bus.src1_in; r.s2 = bus.src2_in; r.wb = bus.wb_en_in;
        r.mr = bus.mem_r_en_in; r.mw = bus.mem_w_en_in; r.s = bus.s_in; r.b = bus.b_in;
        r.imm = bus.imm_in; r.st = bus.status_in;
        return r;
    endfunction

    // Blocking destinations form a set; a hazard is any needed source in that set.
    function automatic logic haz_model();
        int unsigned blk[$];
        int unsigned need[$];
        if (!bus.forward_en) begin
            if (bus.exe_wb_en) blk.push_back(int'(bus.exe_dest));
            if (bus.mem_wb_en) blk.push_back(int'(bus.mem_dest));
        end else if (bus.exe_wb_en && bus.exe_mem_r_en) begin
            blk.push_back(int'(bus.exe_dest));
        end
        need.push_back(int'(bus.src1_in));
        if (bus.two_src_in) need.push_back(int'(bus.src2_in));
        if (!bus.valid_in) return 1'b0;
        foreach (need[i]) foreach (blk[j]) if (need[i] == blk[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        bus.freeze = 0; bus.flush = 0; bus.forward_en = 0; bus.valid_in = 0;
        bus.pc_in = 0; bus.val_rn_in = 0; bus.val_rm_in = 0; bus.imm24_in = 0;
        bus.shift_operand_in = 0; bus.exe_cmd_in = 0; bus.dest_in = 0; bus.src1_in = 0;
        bus.src2_in = 0; bus.two_src_in = 0; bus.wb_en_in = 0; bus.mem_r_en_in = 0;
        bus.mem_w_en_in = 0; bus.s_in = 0; bus.b_in = 0; bus.imm_in = 0; bus.status_in = 0;
        bus.exe_dest = 0; bus.mem_dest = 0; bus.exe_wb_en = 0; bus.mem_wb_en = 0;
        bus.exe_mem_r_en = 0;
    endtask

    task automatic randomize_inputs();
        bus.freeze = ($urandom_range(0, 7) == 0); bus.flush = ($urandom_range(0, 9) == 0);
        bus.forward_en = 1'($urandom); bus.valid_in = ($urandom_range(0, 4) != 0);
        bus.pc_in = $urandom; bus.val_rn_in = $urandom; bus.val_rm_in = $urandom;
        bus.imm24_in = 24'($urandom); bus.shift_operand_in = 12'($urandom);
        bus.exe_cmd_in = 4'($urandom); bus.dest_in = 4'($urandom);
        bus.src1_in = 4'($urandom_range(0, 3)); bus.src2_in = 4'($urandom_range(0, 3));
        bus.two_src_in = 1'($urandom); bus.wb_en_in = 1'($urandom);
        bus.mem_r_en_in = 1'($urandom); bus.mem_w_en_in = 1'($urandom);
        bus.s_in = 1'($urandom); bus.b_in = 1'($urandom); bus.imm_in = 1'($urandom);
        bus.status_in = 4'($urandom); bus.exe_dest = 4'($urandom_range(0, 3));
        bus.mem_dest = 4'($urandom_range(0, 3)); bus.exe_wb_en = 1'($urandom);
        bus.mem_wb_en = 1'($urandom); bus.exe_mem_r_en = 1'($urandom);
    endtask

    // Advance the reference across one rising edge, then settle #1 after it.
    task automatic cycle();
        if (bus.flush) begin
            exp_r = zero_rec();
        end else if (bus.freeze) begin
            exp_r = exp_r;
        end else if (haz_model()) begin
            exp_r = zero_rec();
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end else begin
            exp_r = capture();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"}, bus.valid_out, exp_r.valid);
        chk({tag, ".pc_out"}, bus.pc_out, exp_r.pc);
        chk({tag, ".val_rn_out"}, bus.val_rn_out, exp_r.rn);
        chk({tag, ".val_rm_out"}, bus.val_rm_out, exp_r.rm);
        chk({tag, ".imm24_out"}, bus.imm24_out, exp_r.imm24);
        chk({tag, ".shift_operand_out"}, bus.shift_operand_out, exp_r.sh);
        chk({tag, ".exe_cmd_out"}, bus.exe_cmd_out, exp_r.cmd);
        chk({tag, ".dest_out"}, bus.dest_out, exp_r.dest);
        chk({tag, ".src1_out"}, bus.src1_out, exp_r.s1);
        chk({tag, ".src2_out"}, bus.src2_out, exp_r.s2);
        chk({tag, ".wb_en_out"}, bus.wb_en_out, exp_r.wb);
        chk({tag, ".mem_r_en_out"}, bus.mem_r_en_out, exp_r.mr);
        chk({tag, ".mem_w_en_out"}, bus.mem_w_en_out, exp_r.mw);
        chk({tag, ".s_out"}, bus.s_out, exp_r.s);
        chk({tag, ".b_out"}, bus.b_out, exp_r.b);
        chk({tag, ".imm_out"}, bus.imm_out, exp_r.imm);
        chk({tag, ".status_out"}, bus.status_out, exp_r.st);
        chk({tag, ".bubble_count"}, bus.bubble_count, exp_cnt);
    endtask

    initial begin
        idle();
        exp_r = zero_rec();
        exp_cnt = 0;
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1;

        // power-up release: first edge is an ordinary load
        bus.valid_in = 1; bus.pc_in = 32'h10;
        cycle();
        chk("rel_pc", bus.pc_out, 32'h10);
        check_all("rel");

        // pass-through of every field
        bus.pc_in = 32'h1234_5678; bus.val_rn_in = 32'hDEAD_BEEF; bus.val_rm_in = 32'h0BAD_F00D;
        bus.exe_cmd_in = 4'b0010; bus.imm24_in = 24'h0ABCDE; bus.status_in = 4'b1010;
        bus.shift_operand_in = 12'h5A5; bus.dest_in = 4'd9; bus.src1_in = 4'd1; bus.src2_in = 4'd2;
        bus.wb_en_in = 1; bus.mem_r_en_in = 1; bus.mem_w_en_in = 1; bus.s_in = 1; bus.b_in = 1;
        bus.imm_in = 1;
        #1; chk("pt_hazard", bus.hazard, 1'b0);
        cycle();
        chk("pt_cmd", bus.exe_cmd_out, 4'b0010);
        chk("pt_imm24", bus.imm24_out, 24'h0ABCDE);
        chk("pt_status", bus.status_out, 4'b1010);
        chk("pt_valid", bus.valid_out, 1'b1);
        check_all("pt");

        // non-forwarding RAW against MEM
        bus.forward_en = 0; bus.src1_in = 4'd3; bus.mem_wb_en = 1; bus.mem_dest = 4'd3;
        #1; chk("raw_hazard", bus.hazard, 1'b1);
        cycle();
        chk("raw_valid", bus.valid_out, 1'b0);
        chk("raw_wb", bus.wb_en_out, 1'b0);
        chk("raw_cnt", bus.bubble_count, 16'd1);
        check_all("raw");

        // src2 ignored when two_src_in=0
        bus.src1_in = 4'd7; bus.src2_in = 4'd3; bus.two_src_in = 0;
        #1; chk("src2_unused", bus.hazard, 1'b0);

        // register 0 is a real register
        bus.src1_in = 4'd0; bus.mem_wb_en = 0; bus.exe_wb_en = 1; bus.exe_dest = 4'd0;
        #1; chk("reg0_hazard", bus.hazard, 1'b1);

        // forwarding: only load-use stalls
        idle();
        bus.valid_in = 1; bus.forward_en = 1; bus.exe_wb_en = 1; bus.exe_dest = 4'd5;
        bus.src1_in = 4'd9; bus.src2_in = 4'd5; bus.two_src_in = 1; bus.pc_in = 32'h44;
        bus.mem_wb_en = 1; bus.mem_dest = 4'd9;
        #1; chk("fwd_nohaz", bus.hazard, 1'b0);
        cycle();
        check_all("fwd_load");
        bus.exe_mem_r_en = 1;
        #1; chk("fwd_loaduse", bus.hazard, 1'b1);
        cycle();
        chk("fwd_cnt", bus.bubble_count, 16'd2);
        check_all("fwd_bubble");

        // flush beats hazard
        idle();
        bus.valid_in = 1; bus.pc_in = 32'h20; bus.wb_en_in = 1;
        cycle();
        bus.mem_wb_en = 1; bus.mem_dest = 4'd0; bus.flush = 1;
        #1; chk("flush_haz", bus.hazard, 1'b1);
        cycle();
        chk("flush_valid", bus.valid_out, 1'b0);
        chk("flush_cnt", bus.bubble_count, 16'd2);
        check_all("flush");

        // freeze beats hazard; bubble lands on the first unfrozen edge
        bus.flush = 0; bus.mem_wb_en = 0;
        cycle();
        chk("frz_pre_pc", bus.pc_out, 32'h20);
        bus.mem_wb_en = 1; bus.freeze = 1; bus.pc_in = 32'h30;
        cycle();
        chk("frz_pc", bus.pc_out, 32'h20);
        chk("frz_cnt", bus.bubble_count, 16'd2);
        check_all("frz");
        bus.freeze = 0;
        cycle();
        chk("unfrz_valid", bus.valid_out, 1'b0);
        chk("unfrz_cnt", bus.bubble_count, 16'd3);

        // randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            #1; chk("rnd_hazard", bus.hazard, haz_model());
            cycle();
            check_all("rnd");
        end

        // asynchronous reset in mid-cycle with valid data latched
        idle();
        bus.valid_in = 1; bus.pc_in = 32'h99; bus.wb_en_in = 1;
        cycle();
        chk("mid_pre_valid", bus.valid_out, 1'b1);
        #2; rst = 0; #1;
        exp_r = zero_rec(); exp_cnt = 0;
        check_all("midrst");
        @(posedge clk); #1;
        rst = 1;
        bus.pc_in = 32'h10;
        cycle();
        chk("midrel_pc", bus.pc_out, 32'h10);
        check_all("midrel");

        // saturation of the bubble counter
        bus.forward_en = 0; bus.src1_in = 4'd3; bus.mem_wb_en = 1; bus.mem_dest = 4'd3;
        for (int i = 0; i < 65540; i++) begin
            cycle();
            if (i == 100) chk("sat_mid", bus.bubble_count, exp_cnt);
        end
        chk("sat_cnt", bus.bubble_count, 16'hFFFF);
        check_all("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
Pipeline register between instruction decode and execute, with built-in read-after-write hazard detection.
- Captures all decode-stage outputs and the current status flags on each clock edge.
- Returns a combinational hazard signal to decode, and to the IF/ID register freeze path.
- Inserts a bubble on hazard, holds on freeze, clears on a branch flush.
- Counts inserted bubbles for performance analysis.

Parameters:
DATA_W, 32, width of pc/valRn/valRm
REG_W, 4, register-index width
CNT_W, 16, bubble counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
freeze  input  1  global hold (memory stall)
flush  input  1  branch taken in EX; kill the instruction entering EX
forward_en  input  1  1 = forwarding unit present, only load-use stalls
valid_in  input  1  decode slot holds a real instruction
pc_in, val_rn_in, val_rm_in  input  DATA_W each  decode data
imm24_in  input  24  branch offset
shift_operand_in  input  12  shifter operand
exe_cmd_in  input  4  ALU command
dest_in, src1_in, src2_in  input  REG_W each  register indices
two_src_in  input  1  src2 is read
wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in  input  1 each  control bits
status_in  input  4  NZCV at decode
exe_dest, mem_dest  input  REG_W each  destinations in EX and MEM
exe_wb_en, mem_wb_en  input  1 each  those destinations will be written
exe_mem_r_en  input  1  EX instruction is a load
hazard  output  1  combinational stall request to upstream
valid_out, pc_out, val_rn_out, val_rm_out, imm24_out, shift_operand_out, exe_cmd_out, dest_out, src1_out, src2_out, wb_en_out, mem_r_en_out, mem_w_en_out, s_out, b_out, imm_out, status_out  output  same widths as their _in  registered fields
bubble_count  output  CNT_W  saturating count of bubbles inserted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst=0, every registered output and bubble_count is 0, immediately and without waiting for a clock edge.
- Hazard terms:
  - m_exe(r) = exe_wb_en & (r==exe_dest)
  - m_mem(r) = mem_wb_en & (r==mem_dest)
  - Without forwarding (forward_en=0): hit(r) = m_exe(r) | m_mem(r)
  - With forwarding (forward_en=1): hit(r) = exe_mem_r_en & m_exe(r)
  - hazard = valid_in & (hit(src1_in) | (two_src_in & hit(src2_in)))
  - hazard is purely combinational; it ignores freeze, flush and rst.
- Per rising edge, first matching action wins:
  1. flush=1: load a bubble.
  2. freeze=1: hold all registers.
  3. hazard=1: load a bubble and increment bubble_count.
  4. Otherwise: load every *_in into its *_out, with valid_out = valid_in.
- Bubble definition: every registered output is 0, including valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, s_out and b_out.
- Latency: one cycle from *_in to *_out.
- bubble_count:
  - Increments only in case 3.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Simultaneous events:
  - flush with hazard: flush wins; no count increment.
  - freeze with hazard: hold; no count increment. The bubble is inserted on the first unfrozen edge if the hazard persists.
- Reset mid-operation: registers clear at once. The first edge after release behaves as a normal cycle.
- Register index 0 is an ordinary register: a match on index 0 is a real hazard.

Test Plan:
- Reset: assert rst=0 mid-cycle with valid data latched -> all outputs and bubble_count read 0 before the next edge; after release, with no stall condition, pc_in=0x10 appears at pc_out after one edge.
- Non-forwarding RAW:
  - Setup: forward_en=0, valid_in=1, src1_in=3, mem_wb_en=1, mem_dest=3.
  - Response: hazard=1; next edge yields a bubble (valid_out=0, wb_en_out=0); bubble_count=1.
  - With two_src_in=0, src2_in=3 and no src1 match: hazard=0.
- Forwarding load-use:
  - forward_en=1, exe_wb_en=1, exe_dest=5, src2_in=5, two_src_in=1, exe_mem_r_en=0 -> hazard=0.
  - Setting exe_mem_r_en=1 -> hazard=1 and one bubble.
- Priority:
  - flush=1 with hazard=1 -> bubble, bubble_count unchanged.
  - freeze=1 with hazard=1 -> outputs hold the previous instruction (pc_out=0x20), count unchanged.
- Saturation: force 65540 consecutive hazard cycles -> bubble_count stops at 0xFFFF.
- Pass-through: valid_in=1, exe_cmd_in=4'b0010, imm24_in=0xABCDE, status_in=4'b1010, no hazard -> identical values on the outputs one edge later, valid_out=1.
